proc_fetch_unit: RTL and testbench
==================================

PROC_FETCH_UNIT -- requirements
Module: proc_fetch_unit

Interface
REQ-001 SHALL have parameter p_reset_vector, default 32'h200, the first fetch address after reset.
REQ-002 SHALL have parameter p_max_inflight, default 2, range 1..8, the maximum outstanding imem requests.
REQ-003 SHALL have parameter p_ibuf_depth, default 2, range 1..8, the instruction buffer entries; p_ibuf_depth >= p_max_inflight.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-006 imemreq_val / imemreq_rdy / imemreq_addr  out / in / out  1 / 1 / 32  fetch request handshake.
REQ-007 imemresp_val / imemresp_rdy / imemresp_data  in / out / 32  1 / 1 / 32  fetch response handshake, in order.
REQ-008 pc_sel_F  in  2  redirect select: 0 pc+4, 1 jal, 2 branch, 3 jalr.
REQ-009 jal_target_D, br_target_X, jalr_target_X  in  32 each  redirect targets.
REQ-010 inst_val_D / inst_rdy_D / inst_D / pc_D  out / in / out / out  1 / 1 / 32 / 32  decode-side handshake.
REQ-011 num_fetched, num_dropped  out  32 each  statistics counters (see Configuration).

Function
REQ-012 Request transfer SHALL occur when imemreq_val && imemreq_rdy; pc_F SHALL then advance by 4.
REQ-013 imemreq_val SHALL assert only when (inflight + ibuf occupancy) < p_ibuf_depth, inflight < p_max_inflight, and pc_sel_F == 0.
REQ-014 imemresp_rdy SHALL be tied 1; the REQ-013 credit rule guarantees buffer space.
REQ-015 Accepted responses with drop_cnt == 0 SHALL enqueue {data, pc} into the ibuf the same edge; 1-cycle minimum response-to-inst_val_D latency.
REQ-016 inst_D/pc_D SHALL present the ibuf head; dequeue occurs on inst_val_D && inst_rdy_D.
REQ-017 A redirect (pc_sel_F != 0) SHALL load pc_F with the selected target, flush the ibuf, and set drop_cnt to inflight minus any response accepted that cycle.
REQ-018 The jalr target SHALL have bit 0 cleared; other targets SHALL be used unmodified.
REQ-019 A response arriving while drop_cnt > 0 SHALL be discarded and SHALL decrement drop_cnt.
REQ-020 A response arriving in the redirect cycle SHALL be discarded.
REQ-021 On redirect with a same-cycle dequeue, the flush SHALL win, and inst_val_D SHALL be 0 the next cycle.
REQ-022 Simultaneous request, response and dequeue SHALL update inflight and occupancy by the net change.
REQ-023 Counters inflight and drop_cnt SHALL be $clog2(p_max_inflight+1) bits wide and SHALL never wrap.
REQ-024 pc_F SHALL wrap modulo 2^32 with no error.

Reset
REQ-025 While reset==0: pc_F=p_reset_vector, inflight=0, drop_cnt=0, ibuf empty, imemreq_val=0, inst_val_D=0, counters=0.
REQ-026 Reset asserted mid-operation SHALL abandon all outstanding state; the first request after release SHALL be to p_reset_vector.

Configuration
REQ-027 With PROC_FETCH_STATS_EN defined, num_fetched SHALL increment on every ibuf enqueue and num_dropped on every discarded response.
REQ-028 Without PROC_FETCH_STATS_EN, num_fetched and num_dropped SHALL be constant 0 and no counter flops SHALL be synthesised.

Structure
REQ-029 Package proc_fetch_pkg SHALL hold the pc_sel encodings (PC_SEL_P4/JAL/BR/JALR) and the default reset vector constant.
REQ-030 The ibuf SHALL be a sub-module proc_fetch_ibuf (parametrised depth and width, with flush), instantiated once.

Verification
REQ-031 Release reset with imemreq_rdy=1, 1-cycle responses, inst_rdy_D=1 -> request addrs 0x200, 0x204, 0x208; pc_D follows 0x200, 0x204, 0x208.
REQ-032 With 2 in flight, pulse pc_sel_F=1, jal_target_D=0x300 -> next request addr 0x300; the next 2 responses are dropped; first inst_val_D has pc_D=0x300; num_dropped=2.
REQ-033 Pulse pc_sel_F=3 with jalr_target_X=0x00000005 -> next request addr 0x00000004.
REQ-034 Hold inst_rdy_D=0, depth 2 -> imemreq_val deasserts after 2 requests; releasing inst_rdy_D delivers 0x200, 0x204 in order, then fetch resumes at 0x208.
REQ-035 Drive reset=0 for one cycle with 1 request outstanding -> inst_val_D=0, counters 0, next request addr 0x200.
REQ-036 Redirect and response in the same cycle -> the response is discarded; drop_cnt equals the remaining inflight count.

Source files
------------

// File: rtl/proc_fetch_pkg.sv
// proc_fetch_pkg: shared definitions for the instruction fetch unit.
//   pc_sel_e              redirect select encodings driven on pc_sel_F
//   RESET_VECTOR_DEFAULT  default first fetch address after reset
//   ibuf_entry_t          one instruction buffer entry {inst, pc}
//   jalr_align()          clears bit 0 of a jalr target
package proc_fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEL_P4   = 2'd0,
    PC_SEL_JAL  = 2'd1,
    PC_SEL_BR   = 2'd2,
    PC_SEL_JALR = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0200;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ibuf_entry_t;

  function automatic logic [31:0] jalr_align(input logic [31:0] target);
    return {target[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/proc_fetch_ibuf.sv
// proc_fetch_ibuf: circular instruction buffer with synchronous flush.
//   clk, reset        clock, synchronous active-low reset
//   flush             empties the buffer; wins over a same-cycle dequeue
//   enq_val/enq_data  write one entry (caller guarantees space)
//   deq_rdy           consumer accepts the head this cycle
//   deq_val/deq_data  head entry is valid / head entry
//   count             current occupancy
module proc_fetch_ibuf #(
  parameter int p_depth = 2,
  parameter int p_width = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         enq_val,
  input  logic [p_width-1:0]           enq_data,
  input  logic                         deq_rdy,
  output logic                         deq_val,
  output logic [p_width-1:0]           deq_data,
  output logic [$clog2(p_depth+1)-1:0] count
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  logic [p_width-1:0] mem [p_depth];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               deq_fire;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(p_depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign deq_val  = (count != '0);
  assign deq_data = mem[head];
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq_val)  tail <= ptr_inc(tail);
      if (deq_fire) head <= ptr_inc(head);
      count <= count + CW'(enq_val) - CW'(deq_fire);
    end
  end

  // Storage carries no reset; entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (enq_val) mem[tail] <= enq_data;
  end

endmodule

// File: rtl/proc_fetch_unit.sv
// proc_fetch_unit: in-order instruction fetch with redirect and drop tracking.
// Optional feature: define PROC_FETCH_STATS_EN to build the statistics
// counters; otherwise num_fetched/num_dropped are constant 0.
//   clk, reset                       clock, synchronous active-low reset
//   imemreq_val/rdy/addr             fetch request to instruction memory
//   imemresp_val/rdy/data            in-order fetch response (rdy tied 1)
//   pc_sel_F                         0 pc+4, 1 jal, 2 branch, 3 jalr
//   jal_target_D/br_target_X/jalr_target_X  redirect targets
//   inst_val_D/rdy_D, inst_D, pc_D   instruction handed to decode
//   num_fetched, num_dropped         statistics counters
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// edge where valid and ready are both 1; valid never depends on ready.
module proc_fetch_unit
  import proc_fetch_pkg::*;
#(
  parameter logic [31:0] p_reset_vector = RESET_VECTOR_DEFAULT,
  parameter int          p_max_inflight = 2,
  parameter int          p_ibuf_depth   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemreq_val,
  input  logic        imemreq_rdy,
  output logic [31:0] imemreq_addr,
  input  logic        imemresp_val,
  output logic        imemresp_rdy,
  input  logic [31:0] imemresp_data,
  input  logic [1:0]  pc_sel_F,
  input  logic [31:0] jal_target_D,
  input  logic [31:0] br_target_X,
  input  logic [31:0] jalr_target_X,
  output logic        inst_val_D,
  input  logic        inst_rdy_D,
  output logic [31:0] inst_D,
  output logic [31:0] pc_D,
  output logic [31:0] num_fetched,
  output logic [31:0] num_dropped
);

  localparam int IW = $clog2(p_max_inflight + 1);
  localparam int OW = $clog2(p_ibuf_depth + 1);
  localparam int SW = OW + 1;

  logic [31:0]  pc_f;
  logic [31:0]  resp_pc;
  logic [31:0]  redirect_target;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop_cnt;
  logic [OW-1:0] occ;
  logic         redirect;
  logic         credit_ok;
  logic         req_fire;
  logic         resp_take;
  logic         discard;
  logic         enq;
  logic         head_val;
  ibuf_entry_t  enq_entry;
  ibuf_entry_t  head_entry;

  assign redirect = (pc_sel_F != PC_SEL_P4);

  always_comb begin
    redirect_target = jal_target_D;
    case (pc_sel_F)
      PC_SEL_JAL:  redirect_target = jal_target_D;
      PC_SEL_BR:   redirect_target = br_target_X;
      PC_SEL_JALR: redirect_target = jalr_align(jalr_target_X);
      default:     redirect_target = jal_target_D;
    endcase
  end

  // Every request in flight owns a buffer slot, so a response always fits.
  assign credit_ok    = (SW'(inflight) + SW'(occ)) < SW'(p_ibuf_depth);
  assign imemreq_val  = reset && credit_ok && (inflight < IW'(p_max_inflight)) && !redirect;
  assign imemreq_addr = pc_f;
  assign req_fire     = imemreq_val && imemreq_rdy;

  // A response with nothing outstanding is ignored so inflight cannot wrap.
  assign imemresp_rdy = 1'b1;
  assign resp_take    = imemresp_val && imemresp_rdy && (inflight != '0);
  assign discard      = resp_take && (redirect || (drop_cnt != '0));
  assign enq          = resp_take && !discard;

  // Responses surviving the drop window arrive in request order starting at
  // the last redirect target, so their pc is a running counter.
  assign enq_entry = '{inst: imemresp_data, pc: resp_pc};

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_f     <= p_reset_vector;
      resp_pc  <= p_reset_vector;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + IW'(req_fire) - IW'(resp_take);
      if (redirect) begin
        pc_f     <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= inflight - IW'(resp_take);
      end else begin
        if (req_fire) pc_f <= pc_f + 32'd4;
        if (enq)      resp_pc <= resp_pc + 32'd4;
        if (resp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Flush and dequeue are both driven by redirect; gating deq keeps the
  // flush in charge when both happen together.
  proc_fetch_ibuf #(
    .p_depth (p_ibuf_depth),
    .p_width ($bits(ibuf_entry_t))
  ) u_ibuf (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .enq_val  (enq),
    .enq_data (enq_entry),
    .deq_rdy  (inst_rdy_D && !redirect && reset),
    .deq_val  (head_val),
    .deq_data (head_entry),
    .count    (occ)
  );

  assign inst_val_D = reset && head_val;
  assign inst_D     = head_entry.inst;
  assign pc_D       = head_entry.pc;

`ifdef PROC_FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      num_fetched <= '0;
      num_dropped <= '0;
    end else begin
      if (enq)     num_fetched <= num_fetched + 32'd1;
      if (discard) num_dropped <= num_dropped + 32'd1;
    end
  end
`else
  assign num_fetched = '0;
  assign num_dropped = '0;
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Testbench for proc_fetch_unit: a memory model with random latency answers
// requests; a reference model tracks the expected fetch address and an
// epoch per redirect, and predicts which responses reach decode.
module tb_proc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        imemreq_val, imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val, imemresp_rdy;
  logic [31:0] imemresp_data;
  logic [1:0]  pc_sel_F;
  logic [31:0] jal_target_D, br_target_X, jalr_target_X;
  logic        inst_val_D, inst_rdy_D;
  logic [31:0] inst_D, pc_D;
  logic [31:0] num_fetched, num_dropped;

  proc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .imemreq_val   (imemreq_val),
    .imemreq_rdy   (imemreq_rdy),
    .imemreq_addr  (imemreq_addr),
    .imemresp_val  (imemresp_val),
    .imemresp_rdy  (imemresp_rdy),
    .imemresp_data (imemresp_data),
    .pc_sel_F      (pc_sel_F),
    .jal_target_D  (jal_target_D),
    .br_target_X   (br_target_X),
    .jalr_target_X (jalr_target_X),
    .inst_val_D    (inst_val_D),
    .inst_rdy_D    (inst_rdy_D),
    .inst_D        (inst_D),
    .pc_D          (pc_D),
    .num_fetched   (num_fetched),
    .num_dropped   (num_dropped)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } pend_t;

  pend_t       pending[$];
  logic [63:0] exp_q[$];
  logic [31:0] exp_fetch_pc = 32'h200;
  int epoch = 0, last_due = 0;
  int exp_fetched = 0, exp_dropped = 0, req_fires = 0;
  int compared = 0, mismatched = 0;
  int k_req_rdy_pct = 100, k_inst_rdy_pct = 100, k_redir_pct = 0;
  int k_lat_min = 1, k_lat_max = 1;
  bit redir_prev = 1'b0;

  logic [63:0] mon_e;
  pend_t       mon_p;
  int          mon_due;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cycle(input logic [1:0] sel, input logic [31:0] tgt);
    @(posedge clk); #1;
    imemreq_rdy   = ($urandom_range(99) < k_req_rdy_pct);
    inst_rdy_D    = ($urandom_range(99) < k_inst_rdy_pct);
    jal_target_D  = $urandom & ~32'h3;
    br_target_X   = $urandom & ~32'h3;
    jalr_target_X = $urandom;
    pc_sel_F      = sel;
    case (sel)
      2'd1: jal_target_D  = tgt;
      2'd2: br_target_X   = tgt;
      2'd3: jalr_target_X = tgt;
      default: ;
    endcase
    if (sel != 2'd0) begin
      epoch++;
      exp_fetch_pc = (sel == 2'd3) ? (tgt & ~32'h1) : tgt;
    end
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imemresp_val  = 1'b1;
      imemresp_data = mem_word(pending[0].addr);
      if (pending[0].epoch == epoch) begin
        exp_q.push_back({mem_word(pending[0].addr), pending[0].addr});
        exp_fetched++;
      end else begin
        exp_dropped++;
      end
      void'(pending.pop_front());
    end else begin
      imemresp_val  = 1'b0;
      imemresp_data = $urandom;
    end
  endtask

  task automatic check_stats(input string name);
`ifdef PROC_FETCH_STATS_EN
    check({name, "_num_fetched"}, num_fetched, exp_fetched);
    check({name, "_num_dropped"}, num_dropped, exp_dropped);
`else
    check({name, "_num_fetched"}, num_fetched, 0);
    check({name, "_num_dropped"}, num_dropped, 0);
`endif
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b0;
    pc_sel_F = 2'd0;
    imemresp_val = 1'b0;
    pending.delete();
    exp_q.delete();
    exp_fetch_pc = 32'h200;
    epoch++;
    last_due = 0;
    exp_fetched = 0;
    exp_dropped = 0;
    req_fires = 0;
    repeat (n - 1) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_stats("after_reset");
  endtask

  task automatic wait_pending(input int n);
    int k = 0;
    while (pending.size() < n && k < 50) begin
      drive_cycle(2'd0, 32'h0);
      k++;
    end
    if (pending.size() < n) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pending: outstanding %0d, required %0d", pending.size(), n);
    end
  endtask

  task automatic run_random(input int n);
    logic [1:0]  sel;
    logic [31:0] tgt;
    for (int i = 0; i < n; i++) begin
      sel = 2'd0;
      tgt = 32'h0;
      if ($urandom_range(99) < k_redir_pct) begin
        sel = 2'($urandom_range(3, 1));
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF8;
        else tgt = $urandom & ~32'h3;
        if (sel == 2'd3) tgt = tgt | 32'($urandom_range(1));
      end
      drive_cycle(sel, tgt);
    end
  endtask

  // Stop new requests, let every outstanding response land and be consumed.
  task automatic drain(input string name);
    int s_req, s_inst, s_redir;
    s_req = k_req_rdy_pct; s_inst = k_inst_rdy_pct; s_redir = k_redir_pct;
    k_req_rdy_pct = 0; k_inst_rdy_pct = 100; k_redir_pct = 0;
    repeat (20) drive_cycle(2'd0, 32'h0);
    @(negedge clk);
    check({name, "_undelivered"}, exp_q.size(), 0);
    check_stats(name);
    k_req_rdy_pct = s_req; k_inst_rdy_pct = s_inst; k_redir_pct = s_redir;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      check("reset_req_val", imemreq_val, 0);
      check("reset_inst_val", inst_val_D, 0);
      redir_prev = 1'b0;
    end else begin
      if (redir_prev) check("flush_inst_val", inst_val_D, 0);
      if (inst_val_D && inst_rdy_D && pc_sel_F == 2'd0) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_inst: got pc %h inst %h, expected none", pc_D, inst_D);
        end else begin
          mon_e = exp_q.pop_front();
          check("inst_pc", {inst_D, pc_D}, mon_e);
        end
      end
      if (pc_sel_F != 2'd0) exp_q.delete();
      if (imemreq_val) check("req_during_redirect", pc_sel_F, 0);
      if (imemreq_val && imemreq_rdy) begin
        check("req_addr", imemreq_addr, exp_fetch_pc);
        mon_due = cyc + $urandom_range(k_lat_max, k_lat_min);
        if (mon_due < last_due) mon_due = last_due;
        last_due = mon_due;
        mon_p.addr = exp_fetch_pc;
        mon_p.epoch = epoch;
        mon_p.due = mon_due;
        pending.push_back(mon_p);
        exp_fetch_pc = exp_fetch_pc + 32'd4;
        req_fires++;
      end
      redir_prev = (pc_sel_F != 2'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    imemreq_rdy = 1'b1; inst_rdy_D = 1'b1; pc_sel_F = 2'd0;
    imemresp_val = 1'b0; imemresp_data = '0;
    jal_target_D = '0; br_target_X = '0; jalr_target_X = '0;

    // Straight-line fetch from the reset vector, 1-cycle memory.
    do_reset(3);
    repeat (12) drive_cycle(2'd0, 32'h0);

    // jal redirect with two requests outstanding.
    k_lat_min = 3; k_lat_max = 3;
    wait_pending(2);
    drive_cycle(2'd1, 32'h300);
    repeat (15) drive_cycle(2'd0, 32'h0);
    drain("jal");

    // jalr target with bit 0 set.
    k_lat_min = 1; k_lat_max = 1;
    drive_cycle(2'd3, 32'h0000_0005);
    repeat (10) drive_cycle(2'd0, 32'h0);

    // Decode stalled: fetch must stop at the buffer depth.
    k_inst_rdy_pct = 0;
    do_reset(2);
    repeat (8) drive_cycle(2'd0, 32'h0);
    @(negedge clk);
    check("stall_req_count", req_fires, 2);
    check("stall_req_val", imemreq_val, 0);
    check("stall_head_pc", pc_D, 32'h200);
    k_inst_rdy_pct = 100;
    repeat (10) drive_cycle(2'd0, 32'h0);

    // One-cycle reset with a request outstanding.
    k_lat_min = 3; k_lat_max = 3;
    do_reset(2);
    wait_pending(1);
    do_reset(1);
    repeat (10) drive_cycle(2'd0, 32'h0);
    drain("reset_mid");

    // Randomised traffic, redirects and backpressure.
    k_lat_min = 1;
    for (int r = 0; r < 20; r++) begin
      k_req_rdy_pct  = $urandom_range(100, 30);
      k_inst_rdy_pct = $urandom_range(100, 20);
      k_redir_pct    = $urandom_range(15, 0);
      k_lat_max      = $urandom_range(6, 1);
      run_random(100);
    end
    drain("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
